// File: rtl/team_06_audio_pkg.sv
// Shared constants and types for the team_06 PWM audio output path.
package team_06_audio_pkg;

    localparam int PWM_W = 8;
    localparam logic [PWM_W-1:0] MIDSCALE_DEF = 8'h80;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        PLAY = ST_PLAY
    } state_e;

endpackage

// File: rtl/team_06_sample_fifo.sv
// Power-of-two sample FIFO with a combinational head read; a push is refused
// whenever the FIFO is full, regardless of a same-cycle pop.
module team_06_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/team_06_audio_pwm_out.sv
// 8-bit PWM audio output fed from a sample FIFO, one sample per 256-cycle period.
// Build option TEAM_06_PWM_UNDERRUN_HOLD_EN: repeat the last duty on underrun instead of MIDSCALE.
module team_06_audio_pwm_out
    import team_06_audio_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [PWM_W-1:0] MIDSCALE = MIDSCALE_DEF
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en,
    input  logic [PWM_W-1:0]         sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     pwm_out,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam logic [PWM_W-1:0] CNT_LAST = 8'hFF;
    localparam logic [PWM_W-1:0] CNT_ONE  = 8'h01;

    state_e           state_r;
    logic [PWM_W-1:0] cnt_r;
    logic [PWM_W-1:0] duty_r;
    logic             underrun_r;
    logic [PWM_W-1:0] head_s;
    logic [PWM_W-1:0] under_val_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             period_end_s;

    team_06_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (PWM_W)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (sample_valid),
        .pop   (pop_s),
        .din   (sample_in),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (fifo_count)
    );

`ifdef TEAM_06_PWM_UNDERRUN_HOLD_EN
    assign under_val_s = duty_r;
`else
    assign under_val_s = MIDSCALE;
`endif

    // Pop on PLAY entry and at each period boundary while playback stays enabled.
    always_comb begin
        period_end_s = 1'b0;
        pop_s        = 1'b0;
        if (state_r == PLAY) begin
            period_end_s = en && (cnt_r == CNT_LAST);
        end else begin
            period_end_s = 1'b0;
        end
        if (!empty_s && ((state_r == IDLE && en) || period_end_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Playback FSM, period counter, duty register and underrun pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= IDLE;
            cnt_r      <= {PWM_W{1'b0}};
            duty_r     <= MIDSCALE;
            underrun_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r      <= {PWM_W{1'b0}};
                    underrun_r <= 1'b0;
                    if (en && !empty_s) begin
                        state_r <= PLAY;
                        duty_r  <= head_s;
                    end else begin
                        duty_r  <= MIDSCALE;
                    end
                end
                PLAY: begin
                    if (!en) begin
                        state_r    <= IDLE;
                        cnt_r      <= {PWM_W{1'b0}};
                        duty_r     <= MIDSCALE;
                        underrun_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (period_end_s && !empty_s) begin
                            duty_r     <= head_s;
                            underrun_r <= 1'b0;
                        end else if (period_end_s) begin
                            duty_r     <= under_val_s;
                            underrun_r <= 1'b1;
                        end else begin
                            underrun_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= {PWM_W{1'b0}};
                    duty_r     <= MIDSCALE;
                    underrun_r <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_out      = (state_r == PLAY) && (cnt_r < duty_r);
    assign underrun     = underrun_r;
    assign sample_ready = !full_s;

endmodule

// File: tb/tb_team_06_audio_pwm_out.sv
// Scoreboard bench for team_06_audio_pwm_out: expected per-period duty/underrun
// entries are queued as samples are driven and checked as each period completes.
module tb_team_06_audio_pwm_out;

    typedef struct {
        int duty;
        int urun;
    } sb_t;

    logic       clk;
    logic       nrst;
    logic       en;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_count;

    int  n_cmp;
    int  n_err;
    sb_t exp_q[$];

    team_06_audio_pwm_out dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        exp_q.push_back('{duty: int'(v), urun: 0});
    endtask

    // Observe one period starting at cnt=0; optionally push a sample or drop en at index i.
    task automatic run_period(input int push_at, input logic [7:0] push_val, input int en_off);
        sb_t e;
        int  highs;
        int  lim;
        highs = 0;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 256; i++) begin
            highs += int'(pwm_out);
            if (i == 0) chk("underrun_start", int'(underrun), e.urun);
            if (i == 1) chk("underrun_len", int'(underrun), 0);
            if (i == push_at) begin
                sample_in    = push_val;
                sample_valid = 1'b1;
                exp_q.push_back('{duty: int'(push_val), urun: 0});
            end
            if (i == en_off) en = 1'b0;
            tick();
            if (i == push_at) sample_valid = 1'b0;
            if (i == en_off) begin
                lim = (e.duty < en_off + 1) ? e.duty : en_off + 1;
                chk("partial_highs", highs, lim);
                chk("idle_pwm_after_en_drop", int'(pwm_out), 0);
                return;
            end
        end
        chk("period_highs", highs, e.duty);
    endtask

    initial begin
        logic [7:0] s [5];
        int under_full;
        int under_single;
        n_cmp = 0;
        n_err = 0;
        nrst = 1'b0;
        en = 1'b0;
        sample_in = 8'h00;
        sample_valid = 1'b0;
        s[0] = 8'h11; s[1] = 8'h22; s[2] = 8'h33; s[3] = 8'h44; s[4] = 8'h55;
`ifdef TEAM_06_PWM_UNDERRUN_HOLD_EN
        under_single = 64;
        under_full   = 85;
`else
        under_single = 128;
        under_full   = 128;
`endif

        repeat (3) tick();
        nrst = 1'b1;
        tick();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_underrun", int'(underrun), 0);

        // Single sample then underrun
        sample_in = 8'h40;
        sample_valid = 1'b1;
        en = 1'b1;
        tick();
        exp_q.push_back('{duty: 64, urun: 0});
        chk("single_count_push", int'(fifo_count), 1);
        sample_valid = 1'b0;
        tick();
        chk("single_count_entry", int'(fifo_count), 0);
        run_period(-1, 8'h00, -1);
        exp_q.push_back('{duty: under_single, urun: 1});
        run_period(-1, 8'h00, -1);
        en = 1'b0;
        tick();
        chk("single_idle_pwm", int'(pwm_out), 0);

        // Boundary duties
        push_idle(8'h00);
        push_idle(8'hFF);
        push_idle(8'h80);
        chk("bound_count", int'(fifo_count), 3);
        en = 1'b1;
        tick();
        repeat (3) run_period(-1, 8'h00, -1);
        exp_q.push_back('{duty: 128, urun: 1});
        run_period(-1, 8'h00, -1);
        en = 1'b0;
        tick();

        // Full FIFO, held fifth sample, then en drop mid-period
        for (int k = 0; k < 4; k++) begin
            sample_in = s[k];
            sample_valid = 1'b1;
            chk("full_ready_before", int'(sample_ready), 1);
            tick();
            exp_q.push_back('{duty: int'(s[k]), urun: 0});
        end
        sample_in = s[4];
        chk("full_ready", int'(sample_ready), 0);
        chk("full_count", int'(fifo_count), 4);
        tick();
        tick();
        chk("full_count_held", int'(fifo_count), 4);
        en = 1'b1;
        tick();
        chk("full_count_after_pop", int'(fifo_count), 3);
        run_period(0, s[4], -1);
        run_period(-1, 8'h00, 100);
        chk("endrop_count", int'(fifo_count), 3);
        en = 1'b1;
        tick();
        repeat (3) run_period(-1, 8'h00, -1);
        exp_q.push_back('{duty: under_full, urun: 1});
        run_period(-1, 8'h00, -1);
        en = 1'b0;
        tick();

        // Streaming with push+pop at the period edge
        en = 1'b0;
        push_idle(8'h10);
        push_idle(8'hC0);
        en = 1'b1;
        tick();
        chk("stream_count_entry", int'(fifo_count), 1);
        run_period(255, 8'h33, -1);
        chk("stream_count_1", int'(fifo_count), 1);
        run_period(255, 8'h90, -1);
        chk("stream_count_2", int'(fifo_count), 1);
        run_period(255, 8'h05, -1);
        chk("stream_count_3", int'(fifo_count), 1);

        // Reset mid-PLAY with three samples queued
        sample_in = 8'h66;
        sample_valid = 1'b1;
        tick();
        sample_in = 8'h77;
        tick();
        sample_valid = 1'b0;
        tick();
        chk("prerst_pwm", int'(pwm_out), 1);
        chk("prerst_count", int'(fifo_count), 3);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_pwm", int'(pwm_out), 0);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_ready", int'(sample_ready), 1);
        chk("midrst_underrun", int'(underrun), 0);
        exp_q.delete();
        tick();
        nrst = 1'b1;
        tick();
        chk("postrst_count", int'(fifo_count), 0);
        chk("postrst_pwm", int'(pwm_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/team_06_audio_pwm_out.md
TEAM_06_AUDIO_PWM_OUT -- requirements
Module: team_06_audio_pwm_out

Interface
REQ-001 SHALL have parameter DEPTH, default 4, sample FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MIDSCALE, default 8'h80, duty loaded on underrun and in idle.
REQ-003 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, playback enable.
REQ-006 SHALL have port sample_in, input, 8, unsigned clipped audio sample from the soft-clipping stage.
REQ-007 SHALL have port sample_valid, input, 1, sample_in is offered this cycle.
REQ-008 SHALL have port sample_ready, output, 1, FIFO can accept a sample this cycle.
REQ-009 SHALL have port pwm_out, output, 1, PWM audio bitstream.
REQ-010 SHALL have port underrun, output, 1, one-cycle pulse when a period starts with the FIFO empty.
REQ-011 SHALL have port fifo_count, output, $clog2(DEPTH)+1, current FIFO occupancy.

Function
REQ-012 SHALL push sample_in into the FIFO on any edge where sample_valid && sample_ready.
REQ-013 SHALL drive sample_ready = (fifo_count != DEPTH); a push is refused when full, even if a pop occurs in the same cycle.
REQ-014 SHALL allow a simultaneous push and pop when not full, leaving fifo_count unchanged.
REQ-015 SHALL wrap read/write pointers modulo DEPTH with no data corruption.
REQ-016 SHALL implement a two-state FSM: IDLE and PLAY.
REQ-017 SHALL, in IDLE, hold the 8-bit period counter cnt at 0 and the duty register at MIDSCALE, and drive pwm_out low.
REQ-018 SHALL move from IDLE to PLAY on an edge with en=1 and fifo_count!=0, popping the head into duty and keeping cnt=0.
REQ-019 SHALL, in PLAY, increment cnt every cycle, wrapping 255->0; each period is 256 cycles.
REQ-020 SHALL, on the edge where cnt==255 in PLAY, pop the head into duty if fifo_count!=0; otherwise load the underrun value and pulse underrun for exactly the following cycle.
REQ-021 SHALL drive pwm_out = (state==PLAY) && (cnt < duty), decoded from registered state only: duty 0 gives a constant low, and duty 255 gives 255 of 256 cycles high.
REQ-022 SHALL return to IDLE on the first edge with en=0 in PLAY, with cnt<=0 and duty<=MIDSCALE, and SHALL keep FIFO contents.
REQ-023 SHALL never change duty mid-period except on the PLAY->IDLE exit.
REQ-024 SHALL give a sample pushed into an empty FIFO in IDLE with en=1 a latency of 1 edge to the PLAY entry, with the first pwm_out high on the following cycle if duty>0.

Reset
REQ-025 SHALL, while nrst=0, asynchronously force: state=IDLE, cnt=0, duty=MIDSCALE, FIFO pointers and count=0, pwm_out=0, underrun=0, sample_ready=1.
REQ-026 SHALL discard all FIFO contents and any in-progress period on reset mid-operation.

Configuration
REQ-027 SHALL use macro TEAM_06_PWM_UNDERRUN_HOLD_EN.
- Defined: the underrun value is the previous duty, so the last sample repeats.
- Undefined: the underrun value is MIDSCALE.
- The underrun pulse behaves identically in both builds.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, PLAY), the PWM period width constant (8), and the default MIDSCALE in package team_06_audio_pkg.
REQ-029 SHALL implement the FIFO as sub-module team_06_sample_fifo (push/pop, full/empty, count), instantiated once.

Verification
REQ-030 Reset: nrst=0 mid-PLAY with 3 samples queued -> immediately pwm_out=0, fifo_count=0, sample_ready=1, underrun=0.
REQ-031 Single sample: push 8'h40, en=1 -> PLAY next edge; pwm_out high 64 of 256 cycles; next period loads MIDSCALE (or 8'h40 with the macro) with a one-cycle underrun pulse.
REQ-032 Full FIFO: DEPTH=4, en=0, hold sample_valid with 5 distinct samples -> 4 accepted, sample_ready=0, fifo_count=4; the 5th is held and accepted only after the first pop.
REQ-033 Boundaries: duties 0, 255, 128 -> high counts per period of 0, 255, 128; no high glitch at the wrap.
REQ-034 en drop: en=0 at cnt=100 in PLAY -> IDLE next edge, pwm_out=0, queued samples retained and replayed in order after en=1.
REQ-035 Streaming: one push per 256 cycles with a simultaneous push and pop at the period edge -> no underrun, fifo_count constant, output order matches input order.
